// File: rtl/mac_quant_pkg.sv
// Shared widths, FSM encoding and saturation helper for the beam quantiser / power block.
// Optional per-packet clip counter is enabled by defining MAC_QUANT_SAT_CNT_EN.
package mac_quant_pkg;

    localparam int IW      = 48;
    localparam int OW      = 16;
    localparam int SHIFT_W = 6;
    localparam int CNT_W   = 12;
    localparam int PW      = 40;
    localparam int SH_MAX  = IW - OW;

    // Output range expressed in the IW+1 rounding width so compares need no extension.
    localparam logic signed [IW:0] LIM_HI = (IW+1)'(2**(OW-1) - 1);
    localparam logic signed [IW:0] LIM_LO = ~LIM_HI;

    typedef enum logic [1:0] {IDLE, ACC, REPORT} pwr_st_t;

    // Returns {clip, y}.
    function automatic logic [OW:0] sat_q(input logic signed [IW:0] v);
        if (v > LIM_HI)
            return {1'b1, LIM_HI[OW-1:0]};
        else if (v < LIM_LO)
            return {1'b1, LIM_LO[OW-1:0]};
        else
            return {1'b0, v[OW-1:0]};
    endfunction

endpackage

// File: rtl/mac_round_sat.sv
// One I or Q component: stage 1 round-half-up and arithmetic shift, stage 2 saturate.
module mac_round_sat
    import mac_quant_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [IW-1:0]      i_x,
    input  logic [SHIFT_W-1:0] i_sh,
    output logic [OW-1:0]      o_y,
    output logic               o_clip
);

    logic [IW:0]        w_rnd;
    logic [IW:0]        w_sum;
    logic [OW:0]        w_q;
    logic signed [IW:0] r_s1;

    // One extra bit of headroom so the rounding add never wraps.
    always_comb begin
        w_rnd = '0;
        if (i_sh != '0)
            w_rnd = (IW+1)'(1) << (i_sh - SHIFT_W'(1));
        w_sum = {i_x[IW-1], i_x} + w_rnd;
    end

    assign w_q = sat_q(r_s1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1   <= '0;
            o_y    <= '0;
            o_clip <= 1'b0;
        end else begin
            r_s1   <= $signed(w_sum) >>> i_sh;
            o_y    <= w_q[OW-1:0];
            o_clip <= w_q[OW];
        end
    end

endmodule

// File: rtl/mac_quant_pwr.sv
// Quantises the 48-bit I/Q beam stream to 16-bit {I,Q} and reports per-packet power.
// Define MAC_QUANT_SAT_CNT_EN to report a per-packet clipped-sample count on o_sat_cnt.
module mac_quant_pwr
    import mac_quant_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [IW-1:0]      i_data_i,
    input  logic [IW-1:0]      i_data_q,
    input  logic               i_tvalid,
    input  logic               i_sop,
    input  logic               i_eop,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [2*OW-1:0]    o_data,
    output logic               o_tvalid,
    output logic               o_sop,
    output logic               o_eop,
    output logic               o_sat,
    output logic [PW-1:0]      o_pwr,
    output logic [CNT_W-1:0]   o_pwr_cnt,
    output logic               o_pwr_valid,
    output logic               o_err,
    output logic [CNT_W-1:0]   o_sat_cnt
);

    logic [SHIFT_W-1:0]     r_sh, w_sh_in, w_sh_eff;
    logic [2:1]             r_vld_pipe, r_sop_pipe, r_eop_pipe;
    logic [OW-1:0]          w_i, w_q;
    logic                   w_clip_i, w_clip_q;
    logic signed [2*OW-1:0] w_sq_i, w_sq_q;
    logic                   r_s3_vld, r_s3_sop, r_s3_eop;
    logic [2*OW:0]          r_s3_sq;
    logic [PW-1:0]          w_sq_ext;
    logic [PW:0]            w_acc_sum;
    logic                   w_start;
    pwr_st_t                r_st;
    logic [PW-1:0]          r_acc;
    logic [CNT_W-1:0]       r_cnt;

    // The sop beat itself already uses its own (clamped) shift.
    always_comb begin
        w_sh_in  = (i_shift > SHIFT_W'(SH_MAX)) ? SHIFT_W'(SH_MAX) : i_shift;
        w_sh_eff = (i_tvalid && i_sop) ? w_sh_in : r_sh;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh       <= '0;
            r_vld_pipe <= '0;
            r_sop_pipe <= '0;
            r_eop_pipe <= '0;
        end else begin
            r_sh       <= w_sh_eff;
            r_vld_pipe <= {r_vld_pipe[1], i_tvalid};
            r_sop_pipe <= {r_sop_pipe[1], i_tvalid & i_sop};
            r_eop_pipe <= {r_eop_pipe[1], i_tvalid & i_eop};
        end
    end

    mac_round_sat u_rs_i (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_x     (i_data_i),
        .i_sh    (w_sh_eff),
        .o_y     (w_i),
        .o_clip  (w_clip_i)
    );

    mac_round_sat u_rs_q (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_x     (i_data_q),
        .i_sh    (w_sh_eff),
        .o_y     (w_q),
        .o_clip  (w_clip_q)
    );

    assign o_data   = {w_i, w_q};
    assign o_tvalid = r_vld_pipe[2];
    assign o_sop    = r_sop_pipe[2];
    assign o_eop    = r_eop_pipe[2];
    assign o_sat    = r_vld_pipe[2] & (w_clip_i | w_clip_q);

    assign w_sq_i    = $signed(w_i) * $signed(w_i);
    assign w_sq_q    = $signed(w_q) * $signed(w_q);
    assign w_sq_ext  = {{(PW-2*OW-1){1'b0}}, r_s3_sq};
    assign w_acc_sum = {1'b0, r_acc} + {1'b0, w_sq_ext};
    assign w_start   = r_s3_vld & r_s3_sop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s3_vld <= 1'b0;
            r_s3_sop <= 1'b0;
            r_s3_eop <= 1'b0;
            r_s3_sq  <= '0;
        end else begin
            r_s3_vld <= o_tvalid;
            r_s3_sop <= o_sop;
            r_s3_eop <= o_eop;
            r_s3_sq  <= {1'b0, w_sq_i} + {1'b0, w_sq_q};
        end
    end

    // REPORT publishes the finished packet while a new sop in the same cycle restarts cleanly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_st        <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            o_pwr       <= '0;
            o_pwr_cnt   <= '0;
            o_pwr_valid <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_pwr_valid <= 1'b0;
            o_err       <= 1'b0;
            if (r_st == REPORT) begin
                o_pwr_valid <= 1'b1;
                o_pwr       <= r_acc;
                o_pwr_cnt   <= r_cnt;
            end
            if (w_start) begin
                o_err <= (r_st == ACC);
                r_acc <= w_sq_ext;
                r_cnt <= CNT_W'(1);
                r_st  <= r_s3_eop ? REPORT : ACC;
            end else if (r_s3_vld && r_st == ACC) begin
                r_acc <= w_acc_sum[PW] ? '1 : w_acc_sum[PW-1:0];
                r_cnt <= (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
                if (r_s3_eop)
                    r_st <= REPORT;
            end else begin
                if (r_s3_vld && r_s3_eop)
                    o_err <= 1'b1;
                if (r_st == REPORT)
                    r_st <= IDLE;
            end
        end
    end

`ifdef MAC_QUANT_SAT_CNT_EN
    logic             r_s3_sat;
    logic [CNT_W-1:0] r_sat_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s3_sat  <= 1'b0;
            r_sat_cnt <= '0;
            o_sat_cnt <= '0;
        end else begin
            r_s3_sat <= o_sat;
            if (r_st == REPORT)
                o_sat_cnt <= r_sat_cnt;
            if (w_start)
                r_sat_cnt <= {{(CNT_W-1){1'b0}}, r_s3_sat};
            else if (r_s3_vld && r_st == ACC && r_s3_sat && !(&r_sat_cnt))
                r_sat_cnt <= r_sat_cnt + CNT_W'(1);
        end
    end
`else
    assign o_sat_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_quant_pwr.sv
// Bench for mac_quant_pwr: directed vector table, multi-cycle sequences and random traffic
// checked against a packet-level reference model.
module tb_mac_quant_pwr;
    import mac_quant_pkg::*;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic [IW-1:0]      i_data_i = '0, i_data_q = '0;
    logic               i_tvalid = 1'b0, i_sop = 1'b0, i_eop = 1'b0;
    logic [SHIFT_W-1:0] i_shift = '0;
    logic [2*OW-1:0]    o_data;
    logic               o_tvalid, o_sop, o_eop, o_sat;
    logic [PW-1:0]      o_pwr;
    logic [CNT_W-1:0]   o_pwr_cnt;
    logic               o_pwr_valid, o_err;
    logic [CNT_W-1:0]   o_sat_cnt;

    mac_quant_pwr dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data_i(i_data_i), .i_data_q(i_data_q),
        .i_tvalid(i_tvalid), .i_sop(i_sop), .i_eop(i_eop), .i_shift(i_shift),
        .o_data(o_data), .o_tvalid(o_tvalid), .o_sop(o_sop), .o_eop(o_eop), .o_sat(o_sat),
        .o_pwr(o_pwr), .o_pwr_cnt(o_pwr_cnt), .o_pwr_valid(o_pwr_valid), .o_err(o_err),
        .o_sat_cnt(o_sat_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit vld, sop, eop, sat;
        logic [31:0] data;
        bit pv;
        longint pwr;
        int cnt, scnt;
        bit err;
    } exp_t;

    typedef struct {
        bit v, sop, eop;
        longint i, q;
        int sh;
    } beat_t;

    typedef struct {
        longint i, q;
        int sh, ei, eq;
        bit esat;
        longint epwr;
    } vec_t;

    exp_t   ring[16];
    int     cyc = 0;
    int     n_chk = 0, n_err = 0;
    bit     in_pkt = 0;
    longint msum = 0;
    int     mcnt = 0, msc = 0, msh = 0;
    longint rep_p[$];
    int     rep_c[$];
    int     err_q[$];
    vec_t   tbl[8];

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    function automatic void quant(input longint x, input int sh, output int y, output bit c);
        longint t;
        t = (sh == 0) ? x : (x + (longint'(1) <<< (sh - 1))) >>> sh;
        c = 1'b1;
        if (t > 32767)       y = 32767;
        else if (t < -32768) y = -32768;
        else begin y = int'(t); c = 1'b0; end
    endfunction

    task automatic clear_ring();
        for (int k = 0; k < 16; k++) ring[k] = '{default:0};
    endtask

    task automatic report(input int at);
        ring[at % 16].pv  = 1'b1;
        ring[at % 16].pwr = msum;
        ring[at % 16].cnt = mcnt;
`ifdef MAC_QUANT_SAT_CNT_EN
        ring[at % 16].scnt = msc;
`else
        ring[at % 16].scnt = 0;
`endif
        in_pkt = 0;
    endtask

    // Packet-level view: a packet is open between sop and eop; stray framing is an error.
    task automatic model_in(input beat_t b);
        int yi, yq, s;
        bit ci, cq;
        longint sq;
        if (!b.v) return;
        if (b.sop) msh = (b.sh > 32) ? 32 : b.sh;
        quant(b.i, msh, yi, ci);
        quant(b.q, msh, yq, cq);
        s = (cyc + 2) % 16;
        ring[s].vld = 1'b1; ring[s].sop = b.sop; ring[s].eop = b.eop;
        ring[s].sat = ci | cq; ring[s].data = {16'(yi), 16'(yq)};
        sq = longint'(yi) * yi + longint'(yq) * yq;
        if (b.sop) begin
            if (in_pkt) ring[(cyc + 4) % 16].err = 1'b1;
            in_pkt = 1; msum = sq; mcnt = 1; msc = int'(ci | cq);
            if (b.eop) report(cyc + 5);
        end else if (in_pkt) begin
            msum = msum + sq;
            if (msum > (longint'(1) <<< PW) - 1) msum = (longint'(1) <<< PW) - 1;
            if (mcnt < 4095) mcnt++;
            if ((ci | cq) && msc < 4095) msc++;
            if (b.eop) report(cyc + 5);
        end else if (b.eop) begin
            ring[(cyc + 4) % 16].err = 1'b1;
        end
    endtask

    task automatic check_cycle();
        exp_t e;
        e = ring[cyc % 16];
        chk("tvalid", o_tvalid, e.vld);
        chk("sop", o_sop, e.sop);
        chk("eop", o_eop, e.eop);
        chk("sat", o_sat, e.sat);
        if (e.vld) chk("data", o_data, e.data);
        chk("pwr_valid", o_pwr_valid, e.pv);
        if (e.pv) begin
            chk("pwr", o_pwr, e.pwr);
            chk("pwr_cnt", o_pwr_cnt, e.cnt);
            chk("sat_cnt", o_sat_cnt, e.scnt);
        end
        chk("err", o_err, e.err);
        if (o_pwr_valid) begin rep_p.push_back(longint'(o_pwr)); rep_c.push_back(int'(o_pwr_cnt)); end
        if (o_err) err_q.push_back(cyc);
        ring[cyc % 16] = '{default:0};
    endtask

    // Called at a negedge: drive one beat, advance one clock, check at the next negedge.
    task automatic tick(input beat_t b);
        i_tvalid = b.v; i_sop = b.sop; i_eop = b.eop;
        i_data_i = b.i[IW-1:0]; i_data_q = b.q[IW-1:0]; i_shift = SHIFT_W'(b.sh);
        model_in(b);
        @(posedge i_clk); cyc++;
        @(negedge i_clk);
        check_cycle();
    endtask

    task automatic idle(input int n);
        beat_t b;
        b = '{default:0};
        for (int k = 0; k < n; k++) tick(b);
    endtask

    task automatic beat(input bit sop, input bit eop, input longint i, input longint q, input int sh);
        beat_t b;
        b.v = 1'b1; b.sop = sop; b.eop = eop; b.i = i; b.q = q; b.sh = sh;
        tick(b);
    endtask

    task automatic do_reset(input int n);
        i_rst_n = 1'b0;
        i_tvalid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
        clear_ring();
        in_pkt = 0; msh = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk); cyc++;
            @(negedge i_clk);
            check_cycle();
            chk("rst_data", o_data, 0);
            chk("rst_pwr", o_pwr, 0);
            chk("rst_pwr_cnt", o_pwr_cnt, 0);
            chk("rst_sat_cnt", o_sat_cnt, 0);
        end
        i_rst_n = 1'b1;
    endtask

    initial begin
        int c0, c2;
        beat_t rb;

        tbl[0] = '{i: 100,                q: -50,                sh: 0,  ei: 100,    eq: -50,    esat: 0, epwr: 12500};
        tbl[1] = '{i: 24,                 q: -24,                sh: 4,  ei: 2,      eq: -1,     esat: 0, epwr: 5};
        tbl[2] = '{i: 8,                  q: -8,                 sh: 4,  ei: 1,      eq: 0,      esat: 0, epwr: 1};
        tbl[3] = '{i: 1 <<< 20,           q: -(1 <<< 20),        sh: 0,  ei: 32767,  eq: -32768, esat: 1, epwr: 2147418113};
        tbl[4] = '{i: longint'(1) <<< 40, q: -3 * (longint'(1) <<< 31), sh: 63, ei: 256, eq: -1, esat: 0, epwr: 65537};
        tbl[5] = '{i: -3,                 q: 3,                  sh: 1,  ei: -1,     eq: 2,      esat: 0, epwr: 5};
        tbl[6] = '{i: -(longint'(1) <<< 47), q: (longint'(1) <<< 47) - 1, sh: 0, ei: -32768, eq: 32767, esat: 1, epwr: 2147418113};
        tbl[7] = '{i: (longint'(1) <<< 47) - 1, q: 0,            sh: 32, ei: 32767,  eq: 0,      esat: 1, epwr: 1073676289};

        clear_ring();
        @(negedge i_clk);
        do_reset(3);
        idle(2);

        // Directed single-beat packets: data at +2, report at +5.
        for (int k = 0; k < 8; k++) begin
            beat(1'b1, 1'b1, tbl[k].i, tbl[k].q, tbl[k].sh);
            idle(1);
            chk("tbl_data", o_data, {16'(tbl[k].ei), 16'(tbl[k].eq)});
            chk("tbl_sat", o_sat, tbl[k].esat);
            idle(3);
            chk("tbl_pv", o_pwr_valid, 1);
            chk("tbl_pwr", o_pwr, tbl[k].epwr);
            chk("tbl_cnt", o_pwr_cnt, 1);
`ifdef MAC_QUANT_SAT_CNT_EN
            chk("tbl_sat_cnt", o_sat_cnt, tbl[k].esat);
`else
            chk("tbl_sat_cnt", o_sat_cnt, 0);
`endif
        end

        // Back-to-back packets with no gap.
        rep_p.delete(); rep_c.delete();
        beat(1, 0, 1000, 1000, 0); beat(0, 0, 1000, 1000, 0);
        beat(0, 0, 1000, 1000, 0); beat(0, 1, 1000, 1000, 0);
        beat(1, 0, 10, 20, 0); beat(0, 0, 10, 20, 0); beat(0, 1, 10, 20, 0);
        idle(7);
        chk("b2b_reports", rep_p.size(), 2);
        if (rep_p.size() == 2) begin
            chk("b2b_pwr0", rep_p[0], 8000000);
            chk("b2b_cnt0", rep_c[0], 4);
            chk("b2b_pwr1", rep_p[1], 1500);
            chk("b2b_cnt1", rep_c[1], 3);
        end

        // Missing eop: second sop raises o_err and restarts accumulation.
        rep_p.delete(); rep_c.delete(); err_q.delete();
        beat(1, 0, 1, 1, 0); beat(0, 0, 2, 2, 0); beat(0, 0, 3, 3, 0);
        c2 = cyc;
        beat(1, 0, 4, 0, 0); beat(0, 0, 5, 0, 0); beat(0, 1, 6, 0, 0);
        idle(7);
        chk("noeop_errs", err_q.size(), 1);
        if (err_q.size() == 1) chk("noeop_err_cyc", err_q[0], c2 + 4);
        chk("noeop_reports", rep_p.size(), 1);
        if (rep_p.size() == 1) begin
            chk("noeop_pwr", rep_p[0], 77);
            chk("noeop_cnt", rep_c[0], 3);
        end

        // Reset in the middle of a packet.
        rep_p.delete(); rep_c.delete(); err_q.delete();
        beat(1, 0, 7, 7, 0); beat(0, 0, 8, 8, 0);
        do_reset(3);
        idle(2);
        beat(1, 0, 1, 2, 0); beat(0, 1, 3, 4, 0);
        idle(7);
        chk("rst_reports", rep_p.size(), 1);
        if (rep_p.size() == 1) begin
            chk("rst_pkt_pwr", rep_p[0], 30);
            chk("rst_pkt_cnt", rep_c[0], 2);
        end
        chk("rst_errs", err_q.size(), 0);

        // Random traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            c0 = $urandom_range(0, 99);
            rb.v   = (c0 < 80);
            rb.sop = ($urandom_range(0, 99) < 15);
            rb.eop = ($urandom_range(0, 99) < 15);
            rb.i   = longint'($signed({$urandom(), $urandom()})) >>> $urandom_range(16, 60);
            rb.q   = longint'($signed({$urandom(), $urandom()})) >>> $urandom_range(16, 60);
            rb.sh  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 34));
            tick(rb);
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
